// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and types used by the converter and future decoders.
package gray_pkg;

    localparam int unsigned GRAY_W = 4;

    typedef logic [GRAY_W-1:0] gray_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic gray_t bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR from the MSB down recovers the binary value.
    function automatic logic [GRAY_W-1:0] gray2bin(input gray_t g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int unsigned i = GRAY_W - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward with wrap from last_grant+1; pointer moves only on advance.
module rr_arbiter #(
    parameter  int unsigned N    = 4,
    localparam int unsigned ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] cand_idx;
    int unsigned     cand;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand     = (32'(last_grant) + 1 + i) % N;
            cand_idx = ID_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(N - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one binary-to-Gray stage among N_REQ requesters via round-robin arbitration and a one-entry output register.
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_bin,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_gray,
    output logic [WIDTH-1:0]       out_bin,
    output logic [ID_W-1:0]        out_id
);

    out_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] gray_next;
    logic             can_accept;
    logic             accept;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign out_valid  = (state_q == OUT_FULL);
    assign can_accept = !out_valid || out_ready;
    // Gated by rst_n so nothing handshakes while reset is held low.
    assign req_ready  = (rst_n && can_accept) ? grant : '0;
    assign accept     = |(req_valid & req_ready);
    assign operand    = req_bin[32'(grant_idx)*WIDTH +: WIDTH];

    if (WIDTH == GRAY_W) begin : g_pkg_conv
        assign gray_next = bin2gray(operand);
    end else begin : g_generic_conv
        assign gray_next = operand ^ (operand >> 1);
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = OUT_FULL;
        end else if (out_valid && out_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_gray <= '0;
            out_bin  <= '0;
            out_id   <= '0;
        end else if (accept) begin
            out_gray <= gray_next;
            out_bin  <= operand;
            out_id   <= grant_idx;
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter with hand-computed expected values.
module tb_gray_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_bin;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_gray;
    logic [3:0]  out_bin;
    logic [1:0]  out_id;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    gray_conv_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_bin   (req_bin),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_bin   (out_bin),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [1:0] rr_id   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] rr_gray [6] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h1, 4'h3};
    logic [3:0] rr_rdy  [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_bin   = 16'h0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_gray",  32'(out_gray),  0);
        check("rst_bin",   32'(out_bin),   0);
        check("rst_id",    32'(out_id),    0);
        check("rst_ready", 32'(req_ready), 0);

        // Exhaustive single requester
        req_valid = 4'b0001;
        rst_n     = 1'b1;
        #1;
        for (int unsigned b = 0; b < 16; b++) begin
            req_bin[3:0] = 4'(b);
            #1;
            check("ex_ready", 32'(req_ready), 32'h1);
            tick();
            check("ex_valid", 32'(out_valid), 1);
            check("ex_gray",  32'(out_gray),  32'(gray_tab[b]));
            check("ex_bin",   32'(out_bin),   b);
            check("ex_id",    32'(out_id),    0);
        end

        // Drain without new request
        req_valid = 4'b0000;
        #1;
        check("dr_ready", 32'(req_ready), 0);
        tick();
        check("dr_valid", 32'(out_valid), 0);
        check("dr_gray",  32'(out_gray),  32'h8);
        check("dr_bin",   32'(out_bin),   32'hF);

        // Round robin after reset pointer
        rst_n = 1'b0;
        #1;
        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_bin   = 16'h4321;
        #1;
        check("rr_ready0", 32'(req_ready), 32'h1);
        for (int unsigned k = 0; k < 6; k++) begin
            tick();
            check("rr_valid", 32'(out_valid), 1);
            check("rr_id",    32'(out_id),    32'(rr_id[k]));
            check("rr_gray",  32'(out_gray),  32'(rr_gray[k]));
            check("rr_ready", 32'(req_ready), 32'(rr_rdy[k]));
        end

        // Backpressure: holding id1 (bin 2, gray 3)
        out_ready = 1'b0;
        #1;
        check("bp_ready0", 32'(req_ready), 0);
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            check("bp_valid", 32'(out_valid), 1);
            check("bp_id",    32'(out_id),    1);
            check("bp_gray",  32'(out_gray),  32'h3);
            check("bp_bin",   32'(out_bin),   32'h2);
            check("bp_ready", 32'(req_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(req_ready), 32'b0100);
        tick();
        check("bp_rel_valid", 32'(out_valid), 1);
        check("bp_rel_id",    32'(out_id),    2);
        check("bp_rel_gray",  32'(out_gray),  32'h2);

        // Sparse: only req2/req3; first accept moves pointer to 3
        req_valid = 4'b1100;
        #1;
        check("sp_ready_a", 32'(req_ready), 32'b1000);
        tick();
        check("sp_id_a",   32'(out_id),   3);
        check("sp_gray_a", 32'(out_gray), 32'h6);
        check("sp_ready_b", 32'(req_ready), 32'b0100);
        tick();
        check("sp_id_b",   32'(out_id),   2);
        check("sp_gray_b", 32'(out_gray), 32'h2);
        check("sp_ready_c", 32'(req_ready), 32'b1000);
        tick();
        check("sp_id_c",   32'(out_id),   3);
        check("sp_ready_d", 32'(req_ready), 32'b0100);
        tick();
        check("sp_id_d",   32'(out_id),   2);

        // Reset mid-operation: async drop of out_valid
        req_valid = 4'hF;
        check("mr_pre_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 0);
        check("mr_gray",  32'(out_gray),  0);
        check("mr_ready", 32'(req_ready), 0);
        tick();
        check("mr_hold_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        #1;
        check("mr_rel_ready", 32'(req_ready), 32'h1);
        tick();
        check("mr_first_id",   32'(out_id),   0);
        check("mr_first_gray", 32'(out_gray), 32'h1);
        check("mr_first_bin",  32'(out_bin),  32'h1);

        // Idle after result: drains, data retained
        req_valid = 4'b0000;
        #1;
        check("id_ready", 32'(req_ready), 0);
        tick();
        check("id_valid", 32'(out_valid), 0);
        check("id_gray",  32'(out_gray),  32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
